// File: rtl/bus_ctrl.sv
// bus_ctrl: single-outstanding memory bus controller between the control
// unit and a handshaked memory. A request in IDLE is registered onto the
// memory bus, held through WAIT until MemAck or a bounded timeout, and closed
// by a one-cycle DONE that pulses Done (and BusErr on timeout).
module bus_ctrl #(
  parameter int unsigned WAITMAX = 8
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        CpuRead,
  input  logic        CpuWrite,
  input  logic [15:0] CpuAddr,
  input  logic [15:0] CpuWData,
  output logic [15:0] CpuRData,
  output logic        Stall,
  output logic        Done,
  output logic        BusErr,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  output logic        MemReq,
  output logic        MemWe,
  input  logic [15:0] MemRData,
  input  logic        MemAck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Last counter value that is still allowed to wait; reaching it without an
  // acknowledge ends the transfer with a bus error.
  localparam logic [7:0] CNT_LAST = 8'(WAITMAX - 32'd1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        done_q, done_d;
  logic        buserr_q, buserr_d;

  logic        req_s;
  logic        last_s;

  assign req_s  = CpuRead | CpuWrite;
  assign last_s = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: acknowledge beats timeout, DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (MemAck || last_s) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: Stall must already be high in the request cycle itself.
  always_comb begin
    Stall = 1'b0;
    case (state_q)
      IDLE:    Stall = req_s;
      WAIT:    Stall = 1'b1;
      DONE:    Stall = 1'b0;
      default: Stall = 1'b0;
    endcase
  end

  // Datapath next values: capture on request, complete on ack or timeout.
  always_comb begin
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    done_d      = 1'b0;
    buserr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          mem_addr_d  = CpuAddr;
          mem_wdata_d = CpuWData;
          mem_we_d    = CpuWrite;
          mem_req_d   = 1'b1;
          cnt_d       = 8'd0;
        end else begin
          mem_req_d   = 1'b0;
        end
      end
      WAIT: begin
        if (MemAck) begin
          if (!mem_we_q) begin
            cpu_rdata_d = MemRData;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
          mem_req_d = 1'b0;
          done_d    = 1'b1;
        end else if (last_s) begin
          if (!mem_we_q) begin
            cpu_rdata_d = 16'hFFFF;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          buserr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        mem_req_d = 1'b0;
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt_q       <= 8'd0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      buserr_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      buserr_q    <= buserr_d;
    end
  end

  assign CpuRData = cpu_rdata_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign Done     = done_q;
  assign BusErr   = buserr_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: transaction-level reference for bus_ctrl. Each transfer is
// described by its request, the WAIT cycle on which memory acknowledges, and
// whether the next request is already held during DONE; the expected cycle
// sequence is derived from those numbers directly.
module tb_bus_ctrl;

  localparam int WAITMAX = 8;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        CpuRead, CpuWrite;
  logic [15:0] CpuAddr, CpuWData, CpuRData;
  logic        Stall, Done, BusErr;
  logic [15:0] MemAddr, MemWData, MemRData;
  logic        MemReq, MemWe, MemAck;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_rdata;

  always #5 Clock = ~Clock;

  bus_ctrl #(.WAITMAX(WAITMAX)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .CpuRead  (CpuRead),
    .CpuWrite (CpuWrite),
    .CpuAddr  (CpuAddr),
    .CpuWData (CpuWData),
    .CpuRData (CpuRData),
    .Stall    (Stall),
    .Done     (Done),
    .BusErr   (BusErr),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemReq   (MemReq),
    .MemWe    (MemWe),
    .MemRData (MemRData),
    .MemAck   (MemAck)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Quiet cycles: no request, stray acknowledges must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      CpuRead  = 1'b0;
      CpuWrite = 1'b0;
      CpuAddr  = 16'($urandom);
      MemAck   = 1'($urandom_range(0, 1));
      MemRData = 16'($urandom);
      #1;
      check_eq("idle_stall",  Stall,    1'b0);
      check_eq("idle_memreq", MemReq,   1'b0);
      check_eq("idle_done",   Done,     1'b0);
      check_eq("idle_buserr", BusErr,   1'b0);
      check_eq("idle_rdata",  CpuRData, exp_rdata);
      step();
    end
  endtask

  // One transfer; ack_at is the WAIT cycle index carrying MemAck, and any
  // value >= WAITMAX means memory never answers.
  task automatic xfer(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [15:0] ackdata,
                      input int ack_at, input bit hold);
    bit         to;
    int         nwait;
    logic       we;
    logic [1:0] r;
    to    = (ack_at >= WAITMAX);
    nwait = to ? WAITMAX : ack_at + 1;
    we    = wr;

    CpuRead  = rd;
    CpuWrite = wr;
    CpuAddr  = addr;
    CpuWData = wdata;
    MemAck   = 1'($urandom_range(0, 1));
    MemRData = 16'($urandom);
    #1;
    check_eq("req_stall",  Stall,  1'b1);
    check_eq("req_memreq", MemReq, 1'b0);
    check_eq("req_done",   Done,   1'b0);
    step();

    for (int k = 0; k < nwait; k++) begin
      CpuRead  = 1'($urandom_range(0, 1));
      CpuWrite = 1'($urandom_range(0, 1));
      CpuAddr  = 16'($urandom);
      CpuWData = 16'($urandom);
      MemAck   = (!to && k == ack_at);
      MemRData = (!to && k == ack_at) ? ackdata : 16'($urandom);
      #1;
      check_eq("wait_memreq", MemReq,   1'b1);
      check_eq("wait_we",     MemWe,    we);
      check_eq("wait_addr",   MemAddr,  addr);
      check_eq("wait_wdata",  MemWData, wdata);
      check_eq("wait_stall",  Stall,    1'b1);
      check_eq("wait_done",   Done,     1'b0);
      check_eq("wait_buserr", BusErr,   1'b0);
      check_eq("wait_rdata",  CpuRData, exp_rdata);
      step();
    end

    if (!we) exp_rdata = to ? 16'hFFFF : ackdata;

    if (hold) begin
      r        = 2'($urandom_range(1, 3));
      CpuRead  = r[0];
      CpuWrite = r[1];
    end else begin
      CpuRead  = 1'b0;
      CpuWrite = 1'b0;
    end
    MemAck   = 1'($urandom_range(0, 1));
    MemRData = 16'($urandom);
    #1;
    check_eq("done_done",   Done,     1'b1);
    check_eq("done_buserr", BusErr,   to);
    check_eq("done_stall",  Stall,    1'b0);
    check_eq("done_memreq", MemReq,   1'b0);
    check_eq("done_rdata",  CpuRData, exp_rdata);
    step();
  endtask

  initial begin
    logic [1:0] r;
    bit         h;
    nReset   = 1'b0;
    CpuRead  = 1'b0;
    CpuWrite = 1'b0;
    CpuAddr  = 16'h0000;
    CpuWData = 16'h0000;
    MemAck   = 1'b0;
    MemRData = 16'h0000;
    exp_rdata = 16'h0000;
    #2;
    check_eq("rst_memreq", MemReq,   1'b0);
    check_eq("rst_memwe",  MemWe,    1'b0);
    check_eq("rst_addr",   MemAddr,  16'h0000);
    check_eq("rst_wdata",  MemWData, 16'h0000);
    check_eq("rst_rdata",  CpuRData, 16'h0000);
    check_eq("rst_done",   Done,     1'b0);
    check_eq("rst_buserr", BusErr,   1'b0);
    check_eq("rst_stall",  Stall,    1'b0);
    @(negedge Clock);
    @(negedge Clock);
    nReset = 1'b1;

    // Directed scenarios.
    xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 0, 1'b0);
    idle(1);
    xfer(1'b0, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 3, 1'b0);
    idle(1);
    xfer(1'b1, 1'b0, 16'h2222, 16'h0000, 16'h1111, 100, 1'b0);
    idle(1);
    xfer(1'b1, 1'b0, 16'h3333, 16'h0000, 16'h5A5A, WAITMAX - 1, 1'b0);
    xfer(1'b0, 1'b1, 16'h4444, 16'h9999, 16'h0000, 100, 1'b0);
    xfer(1'b1, 1'b1, 16'h5555, 16'hCAFE, 16'h0000, 1, 1'b1);
    xfer(1'b1, 1'b0, 16'h6666, 16'h0000, 16'h7777, 2, 1'b0);
    idle(2);

    // Reset asserted between edges in the middle of WAIT.
    CpuRead  = 1'b1;
    CpuWrite = 1'b0;
    CpuAddr  = 16'h7777;
    MemAck   = 1'b0;
    step();
    CpuRead = 1'b0;
    step();
    check_eq("pre_rst_memreq", MemReq, 1'b1);
    #3;
    nReset = 1'b0;
    #1;
    exp_rdata = 16'h0000;
    check_eq("midrst_memreq", MemReq,   1'b0);
    check_eq("midrst_stall",  Stall,    1'b0);
    check_eq("midrst_addr",   MemAddr,  16'h0000);
    check_eq("midrst_rdata",  CpuRData, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("midrst_done",   Done,   1'b0);
      check_eq("midrst_buserr", BusErr, 1'b0);
    end
    @(negedge Clock);
    nReset = 1'b1;
    xfer(1'b1, 1'b0, 16'h8888, 16'h0000, 16'h1357, 2, 1'b0);
    idle(1);

    // Randomized transfers.
    for (int t = 0; t < 60; t++) begin
      r = 2'($urandom_range(1, 3));
      h = 1'($urandom_range(0, 1));
      xfer(r[0], r[1], 16'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(0, WAITMAX + 1), h);
      if (!h) idle($urandom_range(0, 2));
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 The block SHALL have parameter WAITMAX, default 8: the maximum number of cycles in WAIT without MemAck before a bus error (legal range 1..255).
REQ-002 The block SHALL have the following ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- nReset  input  1  reset; asynchronous, active-low.
- CpuRead  input  1  read request from the control unit (instruction fetch or load).
- CpuWrite  input  1  write request from the control unit (store).
- CpuAddr  input  16  word address, driven from the datapath system bus.
- CpuWData  input  16  store data, driven from the datapath system bus.
- CpuRData  output  16  registered read data, feeds the datapath DataIn.
- Stall  output  1  the control unit shall hold its state while this is high.
- Done  output  1  one-cycle pulse marking the end of a transfer.
- BusErr  output  1  one-cycle pulse, coincident with Done, when a transfer times out.
- MemAddr  output  16  registered address to memory.
- MemWData  output  16  registered write data to memory.
- MemReq  output  1  memory request, registered.
- MemWe  output  1  1 = write, 0 = read; valid while MemReq is high.
- MemRData  input  16  read data from memory, valid with MemAck.
- MemAck  input  1  memory completion, sampled only in WAIT.

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, WAIT and DONE, encoded as an enumerated type.
REQ-004 In IDLE, if CpuRead or CpuWrite is high at a rising edge, the block SHALL latch CpuAddr into MemAddr and CpuWData into MemWData.
REQ-005 On that same edge it SHALL set MemWe = CpuWrite, set MemReq = 1, clear the wait counter and enter WAIT.
REQ-006 When CpuRead and CpuWrite are both high in IDLE, the write SHALL take priority (MemWe = 1).
REQ-007 Stall SHALL be combinational: (IDLE and (CpuRead or CpuWrite)) or WAIT, so it is high in the request cycle itself.
REQ-008 Stall SHALL be low in DONE.
REQ-009 In WAIT, MemReq SHALL stay high, and MemAddr, MemWData and MemWe SHALL stay stable.
REQ-010 In WAIT, the 8-bit wait counter SHALL increment by 1 each cycle MemAck is low.
REQ-011 In WAIT with MemAck high, the block SHALL load MemRData into CpuRData if MemWe = 0, clear MemReq and enter DONE.
REQ-012 CpuRData SHALL be left unchanged on a write.
REQ-013 In WAIT with MemAck low and counter = WAITMAX-1, the block SHALL clear MemReq and load 16'hFFFF into CpuRData if MemWe = 0.
REQ-014 On that timeout it SHALL set the BusErr register and enter DONE.
REQ-015 If MemAck arrives on the same cycle the counter reaches WAITMAX-1, the acknowledge SHALL win and no BusErr SHALL be raised.
REQ-016 DONE SHALL last exactly one cycle with Done = 1, and BusErr high only if the transfer timed out; it then SHALL return to IDLE unconditionally.
REQ-017 CpuRead and CpuWrite SHALL be ignored in WAIT and DONE.
REQ-018 A request still asserted on return to IDLE SHALL start a new transfer.
REQ-019 Minimum latency SHALL be 3 edges: request edge to WAIT, ack edge to DONE, then Done seen for one cycle, giving back-to-back transfers every 3 cycles.
REQ-020 CpuRData SHALL hold its value between transfers.
REQ-021 MemAck in IDLE or DONE SHALL be ignored.

Reset
REQ-022 While nReset is low, the block SHALL immediately force state = IDLE, counter = 0, MemReq = 0, MemWe = 0, MemAddr = 0, MemWData = 0, CpuRData = 0, Done = 0 and BusErr = 0, independent of Clock.
REQ-023 A reset asserted mid-transfer SHALL abort the transfer with no Done or BusErr pulse.
REQ-024 After reset release, the first rising edge SHALL sample requests normally.

Verification
REQ-025 Read with immediate ack: CpuRead=1, CpuAddr=16'h0010; MemAck=1 and MemRData=16'hA5A5 on the first WAIT cycle -> MemReq high 1 cycle, MemWe=0, MemAddr=16'h0010, Done pulses 2 cycles after the request edge, CpuRData=16'hA5A5, Stall high for 2 cycles.
REQ-026 Write with 3 wait states: CpuWrite=1, CpuAddr=16'h1234, CpuWData=16'hBEEF; MemAck on the 4th WAIT cycle -> MemWe=1, MemWData=16'hBEEF held stable 4 cycles, Done pulses once, CpuRData unchanged.
REQ-027 Timeout: CpuRead=1 with MemAck tied low, WAITMAX=8 -> MemReq high exactly 8 cycles, then Done=1 with BusErr=1, CpuRData=16'hFFFF.
REQ-028 Boundary ack: MemAck rises on the 8th WAIT cycle, WAITMAX=8 -> Done=1, BusErr=0, CpuRData=MemRData.
REQ-029 Simultaneous requests: CpuRead=CpuWrite=1 -> MemWe=1 (write priority); a request held high through DONE -> second MemReq begins the cycle after Done.
REQ-030 Reset mid-WAIT: nReset driven low between clock edges -> MemReq=0 and state IDLE at once, no Done pulse; the next request after release completes normally.
